// File: rtl/hazard_scoreboard_if.sv
// Purpose: decode-stage bundle between the decoder and the hazard scoreboard.
// Ports (master = decoder side, slave = scoreboard side):
//   flush, stall_ext, valid_in          pipeline control
//   ra, rd_hi, rd_lo                    sources read by the decoded instruction
//   wen, wdst, whi, wlo, lat            destinations written and their result latency
//   done_vld, done_sel                  completion pulses from multi-cycle units
//   stall_out, issue, pending           scoreboard responses
interface hazard_scoreboard_if #(
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned CNT_W    = 3,
    parameter int unsigned NUM_DONE = 1
);
    logic                    flush;
    logic                    stall_ext;
    logic                    valid_in;
    logic [NUM_SRC*5-1:0]    ra;
    logic                    rd_hi;
    logic                    rd_lo;
    logic                    wen;
    logic [4:0]              wdst;
    logic                    whi;
    logic                    wlo;
    logic [CNT_W-1:0]        lat;
    logic [NUM_DONE-1:0]     done_vld;
    logic [NUM_DONE*6-1:0]   done_sel;
    logic                    stall_out;
    logic                    issue;
    logic [33:0]             pending;

    modport master (
        output flush, stall_ext, valid_in, ra, rd_hi, rd_lo,
               wen, wdst, whi, wlo, lat, done_vld, done_sel,
        input  stall_out, issue, pending
    );

    modport slave (
        input  flush, stall_ext, valid_in, ra, rd_hi, rd_lo,
               wen, wdst, whi, wlo, lat, done_vld, done_sel,
        output stall_out, issue, pending
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Purpose: register-hazard scoreboard for decode. Keeps a countdown per GPR plus HI/LO
// giving the cycles until an in-flight result becomes forwardable; the all-ones count
// marks an unknown-latency producer that waits for a completion pulse.
// Ports:
//   clk      clock
//   resetn   synchronous active-low reset
//   bus      hazard_scoreboard_if.slave (decoder requests in, stall_out/issue/pending out)
// stall_out, issue and pending are combinational from the counters and the current inputs.
// Module parameters must match those of the connected interface instance.
module hazard_scoreboard #(
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned CNT_W    = 3,
    parameter int unsigned NUM_DONE = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    hazard_scoreboard_if.slave   bus
);

    localparam int unsigned NUM_ENT = 34;
    localparam int unsigned HI_IDX  = 32;
    localparam int unsigned LO_IDX  = 33;
    localparam logic [CNT_W-1:0] LAT_INF = {CNT_W{1'b1}};

    logic [CNT_W-1:0]   r_cnt     [NUM_ENT];
    logic [CNT_W-1:0]   w_cnt_nxt [NUM_ENT];
    logic [NUM_ENT-1:0] w_pend;
    logic [NUM_ENT-1:0] w_inf;
    logic [NUM_ENT-1:0] w_dst;
    logic [NUM_ENT-1:0] w_done;
    logic               w_hazard;
    logic               w_issue;

    // Per-entry status flags.
    always_comb begin : entry_status
        for (int unsigned e = 0; e < NUM_ENT; e++) begin
            w_pend[e] = (r_cnt[e] != '0);
            w_inf[e]  = (r_cnt[e] == LAT_INF);
        end
    end

    // Destination entries written by the decoded instruction; $zero is never tracked.
    always_comb begin : dst_mask
        w_dst = '0;
        if (bus.wen && (bus.wdst != 5'd0)) begin
            w_dst[{1'b0, bus.wdst}] = 1'b1;
        end
        w_dst[HI_IDX] = bus.whi;
        w_dst[LO_IDX] = bus.wlo;
    end

    // Completion pulses OR together; selectors past LO are ignored.
    always_comb begin : done_mask
        w_done = '0;
        for (int unsigned k = 0; k < NUM_DONE; k++) begin
            if (bus.done_vld[k] && (bus.done_sel[k*6 +: 6] < 6'(NUM_ENT))) begin
                w_done[bus.done_sel[k*6 +: 6]] = 1'b1;
            end
        end
    end

    // RAW on any source, plus WAW only against unknown-latency producers
    // (a finite pending write is simply overtaken by the newer one).
    always_comb begin : hazard_detect
        logic [4:0] v_src;
        v_src    = 5'd0;
        w_hazard = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            v_src = bus.ra[i*5 +: 5];
            if ((v_src != 5'd0) && w_pend[{1'b0, v_src}]) begin
                w_hazard = 1'b1;
            end
        end
        if (bus.rd_hi && w_pend[HI_IDX]) w_hazard = 1'b1;
        if (bus.rd_lo && w_pend[LO_IDX]) w_hazard = 1'b1;
        if (bus.wen && (bus.wdst != 5'd0) && w_inf[{1'b0, bus.wdst}]) w_hazard = 1'b1;
        if (bus.whi && w_inf[HI_IDX]) w_hazard = 1'b1;
        if (bus.wlo && w_inf[LO_IDX]) w_hazard = 1'b1;
    end

    assign w_issue       = bus.valid_in & ~w_hazard & ~bus.stall_ext & ~bus.flush;
    assign bus.issue     = w_issue;
    assign bus.stall_out = bus.valid_in & w_hazard;
    assign bus.pending   = w_pend;

    // Counter update: flush clears everything; a new issue overrides the entry;
    // unknown-latency entries hold until done; finite counts tick unless frozen.
    always_comb begin : next_state
        for (int unsigned e = 0; e < NUM_ENT; e++) begin
            w_cnt_nxt[e] = r_cnt[e];
        end
        if (bus.flush) begin
            for (int unsigned e = 0; e < NUM_ENT; e++) begin
                w_cnt_nxt[e] = '0;
            end
        end else begin
            for (int unsigned e = 1; e < NUM_ENT; e++) begin
                if (w_issue && w_dst[e]) begin
                    w_cnt_nxt[e] = bus.lat;
                end else if (w_inf[e]) begin
                    if (w_done[e]) begin
                        w_cnt_nxt[e] = '0;
                    end
                end else if (!bus.stall_ext && w_pend[e]) begin
                    w_cnt_nxt[e] = r_cnt[e] - CNT_W'(1);
                end
            end
        end
        w_cnt_nxt[0] = '0;
    end

    // Counter registers.
    always_ff @(posedge clk) begin : cnt_reg
        if (!resetn) begin
            for (int unsigned e = 0; e < NUM_ENT; e++) begin
                r_cnt[e] <= '0;
            end
        end else begin
            for (int unsigned e = 0; e < NUM_ENT; e++) begin
                r_cnt[e] <= w_cnt_nxt[e];
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Purpose: self-checking bench for hazard_scoreboard. A reference model keeps, per entry,
// the remaining cycles (or an "unknown latency" flag); expected outputs are queued when
// stimulus is applied and a negedge monitor pops and compares them.
module tb_hazard_scoreboard;

    localparam int unsigned NUM_SRC  = 2;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned NUM_DONE = 1;
    localparam int          NUM_ENT  = 34;
    localparam int          LAT_INF  = 7;

    typedef struct {
        bit valid;
        int ra0;
        int ra1;
        bit rd_hi;
        bit rd_lo;
        bit wen;
        int wdst;
        bit whi;
        bit wlo;
        int lat;
        bit flush;
        bit stall_ext;
        bit done_vld;
        int done_sel;
    } stim_t;

    typedef struct {
        bit        stall;
        bit        iss;
        bit [33:0] pend;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    int m_rem [NUM_ENT];
    bit m_inf [NUM_ENT];

    hazard_scoreboard_if #(.NUM_SRC(NUM_SRC), .CNT_W(CNT_W), .NUM_DONE(NUM_DONE)) bus ();

    hazard_scoreboard #(.NUM_SRC(NUM_SRC), .CNT_W(CNT_W), .NUM_DONE(NUM_DONE)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic stim_t idle();
        stim_t s;
        s.valid = 0; s.ra0 = 0; s.ra1 = 0; s.rd_hi = 0; s.rd_lo = 0;
        s.wen = 0; s.wdst = 0; s.whi = 0; s.wlo = 0; s.lat = 0;
        s.flush = 0; s.stall_ext = 0; s.done_vld = 0; s.done_sel = 0;
        return s;
    endfunction

    function automatic bit m_busy(int e);
        return m_inf[e] || (m_rem[e] > 0);
    endfunction

    function automatic bit writes(stim_t s, int e);
        return (s.wen && s.wdst != 0 && s.wdst == e) || (e == 32 && s.whi) || (e == 33 && s.wlo);
    endfunction

    function automatic exp_t predict(stim_t s);
        exp_t x;
        bit   h;
        h = (s.ra0 != 0 && m_busy(s.ra0)) || (s.ra1 != 0 && m_busy(s.ra1)) ||
            (s.rd_hi && m_busy(32)) || (s.rd_lo && m_busy(33)) ||
            (s.wen && s.wdst != 0 && m_inf[s.wdst]) || (s.whi && m_inf[32]) || (s.wlo && m_inf[33]);
        x.stall = s.valid && h;
        x.iss   = s.valid && !h && !s.stall_ext && !s.flush;
        for (int e = 0; e < NUM_ENT; e++) x.pend[e] = m_busy(e);
        return x;
    endfunction

    task automatic model_update(input stim_t s, input bit iss, input bit rst);
        for (int e = 0; e < NUM_ENT; e++) begin
            if (rst || s.flush) begin
                m_rem[e] = 0;
                m_inf[e] = 0;
            end else if (e == 0) begin
                m_rem[e] = 0;
            end else if (iss && writes(s, e)) begin
                m_inf[e] = (s.lat == LAT_INF);
                m_rem[e] = (s.lat == LAT_INF) ? 0 : s.lat;
            end else if (m_inf[e]) begin
                if (s.done_vld && s.done_sel == e) m_inf[e] = 0;
            end else if (!s.stall_ext && m_rem[e] > 0) begin
                m_rem[e] = m_rem[e] - 1;
            end
        end
    endtask

    task automatic drive(input stim_t s);
        bus.valid_in  = s.valid;
        bus.ra        = {5'(s.ra1), 5'(s.ra0)};
        bus.rd_hi     = s.rd_hi;
        bus.rd_lo     = s.rd_lo;
        bus.wen       = s.wen;
        bus.wdst      = 5'(s.wdst);
        bus.whi       = s.whi;
        bus.wlo       = s.wlo;
        bus.lat       = 3'(s.lat);
        bus.flush     = s.flush;
        bus.stall_ext = s.stall_ext;
        bus.done_vld  = s.done_vld;
        bus.done_sel  = 6'(s.done_sel);
    endtask

    // One clock of stimulus: queue the expectation, sample raw outputs, advance the model.
    task automatic step(input stim_t s, output bit gi, output bit gs);
        exp_t x;
        drive(s);
        x = predict(s);
        exp_q.push_back(x);
        @(negedge clk);
        gi = bus.issue;
        gs = bus.stall_out;
        @(posedge clk);
        model_update(s, x.iss, !resetn);
        #1;
    endtask

    // Hold a dependent instruction until it issues and compare the stall cycle count.
    task automatic run_dep(input stim_t s, input int exp_stalls, input int done_at,
                           input int ext_lo, input int ext_hi, input string name);
        stim_t t;
        bit    gi, gs, issued;
        int    stalls;
        stalls = 0;
        issued = 0;
        for (int c = 1; c <= 40 && !issued; c++) begin
            t           = s;
            t.done_vld  = (c == done_at);
            t.stall_ext = (c >= ext_lo && c <= ext_hi);
            step(t, gi, gs);
            if (gi) issued = 1;
            else if (gs) stalls++;
        end
        n_checks++;
        if (!issued || stalls != exp_stalls) begin
            n_errors++;
            $display("FAIL %s: stall cycles %0d issued %0b, expected %0d stalls then issue",
                     name, stalls, issued, exp_stalls);
        end
    endtask

    // Monitor: every cycle with a queued expectation is compared at the negedge.
    always @(negedge clk) begin
        exp_t x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            n_checks += 3;
            if (bus.stall_out !== x.stall) begin
                n_errors++;
                $display("FAIL stall_out @%0t: got %b expected %b", $time, bus.stall_out, x.stall);
            end
            if (bus.issue !== x.iss) begin
                n_errors++;
                $display("FAIL issue @%0t: got %b expected %b", $time, bus.issue, x.iss);
            end
            if (bus.pending !== x.pend) begin
                n_errors++;
                $display("FAIL pending @%0t: got %h expected %h", $time, bus.pending, x.pend);
            end
        end
    end

    initial begin
        stim_t s;
        bit    gi, gs;
        int    r;

        resetn = 1'b0;
        drive(idle());
        repeat (2) @(posedge clk);
        model_update(idle(), 1'b0, 1'b1);
        #1;
        resetn = 1'b1;

        // Reset state, then a reader right after reset must not stall.
        step(idle(), gi, gs);
        s = idle(); s.valid = 1; s.ra0 = 1; s.rd_hi = 1; s.rd_lo = 1;
        step(s, gi, gs);

        // Load-use: one stall cycle.
        s = idle(); s.valid = 1; s.wen = 1; s.wdst = 2; s.lat = 1;
        step(s, gi, gs);
        s = idle(); s.valid = 1; s.ra0 = 2; s.ra1 = 4; s.wen = 1; s.wdst = 3;
        run_dep(s, 1, -1, 0, -1, "load_use");

        // Divide writing HI/LO, mflo waits for the done pulse on LO.
        s = idle(); s.valid = 1; s.whi = 1; s.wlo = 1; s.lat = LAT_INF;
        step(s, gi, gs);
        s = idle(); s.valid = 1; s.rd_lo = 1; s.wen = 1; s.wdst = 9; s.done_sel = 33;
        run_dep(s, 10, 10, 0, -1, "div_mflo");
        s = idle(); s.done_vld = 1; s.done_sel = 32;
        step(s, gi, gs);

        // Countdown frozen by an external stall.
        s = idle(); s.valid = 1; s.wen = 1; s.wdst = 5; s.lat = 3;
        step(s, gi, gs);
        s = idle(); s.valid = 1; s.ra1 = 5;
        run_dep(s, 5, -1, 2, 3, "stall_ext_freeze");

        // Flush blocks issue and kills an unknown-latency producer.
        s = idle(); s.valid = 1; s.wen = 1; s.wdst = 7; s.lat = 2; s.flush = 1;
        step(s, gi, gs);
        n_checks++;
        if (gi != 1'b0) begin
            n_errors++;
            $display("FAIL flush_issue: got %b expected 0", gi);
        end
        step(idle(), gi, gs);
        s = idle(); s.valid = 1; s.wen = 1; s.wdst = 10; s.lat = LAT_INF;
        step(s, gi, gs);
        step(idle(), gi, gs);
        s = idle(); s.flush = 1;
        step(s, gi, gs);
        step(idle(), gi, gs);

        // Writes to $zero are never tracked.
        s = idle(); s.valid = 1; s.wen = 1; s.wdst = 0; s.lat = 3;
        step(s, gi, gs);
        s = idle(); s.valid = 1; s.wen = 1; s.wdst = 11;
        run_dep(s, 0, -1, 0, -1, "read_r0");

        // A lat=0 rewrite overtakes a finite pending write.
        s = idle(); s.valid = 1; s.wen = 1; s.wdst = 8; s.lat = 2;
        step(s, gi, gs);
        s = idle(); s.valid = 1; s.wen = 1; s.wdst = 8; s.lat = 0;
        step(s, gi, gs);
        s = idle(); s.valid = 1; s.ra0 = 8;
        run_dep(s, 0, -1, 0, -1, "overtake_r8");

        // Randomized traffic on a small register set to provoke hazards.
        for (int n = 0; n < 2500; n++) begin
            s = idle();
            s.valid     = ($urandom_range(0, 9) < 7);
            s.ra0       = $urandom_range(0, 7);
            s.ra1       = $urandom_range(0, 7);
            s.rd_hi     = ($urandom_range(0, 5) == 0);
            s.rd_lo     = ($urandom_range(0, 5) == 0);
            s.wen       = ($urandom_range(0, 2) != 0);
            s.wdst      = $urandom_range(0, 7);
            s.whi       = ($urandom_range(0, 7) == 0);
            s.wlo       = ($urandom_range(0, 7) == 0);
            r = $urandom_range(0, 9);
            s.lat       = (r < 3) ? 0 : (r < 5) ? 1 : (r < 7) ? LAT_INF : $urandom_range(2, 6);
            s.flush     = ($urandom_range(0, 59) == 0);
            s.stall_ext = ($urandom_range(0, 4) == 0);
            s.done_vld  = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 3);
            s.done_sel  = (r == 0) ? 32 : (r == 1) ? 33 : (r == 2) ? $urandom_range(0, 7)
                                                                   : $urandom_range(34, 63);
            resetn = ($urandom_range(0, 299) != 0);
            step(s, gi, gs);
        end
        resetn = 1'b1;
        repeat (3) step(idle(), gi, gs);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
